// File: rtl/bib_hakem.sv
// Two-requester round-robin front end for the shared 3-bit-opcode ALU.
// Grants one instruction at a time, executes it, and holds the result until consumed.
module bib_hakem (
  input  logic       clk,
  input  logic       rst,
  input  logic       istek0,
  input  logic [8:0] buyruk0,
  output logic       kabul0,
  input  logic       istek1,
  input  logic [8:0] buyruk1,
  output logic       kabul1,
  output logic [3:0] sonuc,
  output logic       sonuc_gecerli,
  output logic       sonuc_kim,
  input  logic       sonuc_al,
  output logic [7:0] islem_sayaci
);

  localparam int unsigned BUYRUK_W = 9;
  localparam int unsigned SONUC_W  = 4;
  localparam int unsigned SAYAC_W  = 8;

  typedef enum logic [1:0] {BOSTA, YURUT, SUNUM} durum_t;

  durum_t               durum, durum_n;
  logic [BUYRUK_W-1:0]  komut, komut_n;
  logic [SONUC_W-1:0]   sonuc_n, alu_y;
  logic                 gecerli_n, kim_n;
  logic                 oncelik, oncelik_n;
  logic [SAYAC_W-1:0]   sayac_n;
  logic                 talep, kazanan;
  logic [2:0]           alu_a, alu_b;

  // ALU on the latched instruction; upper bits zero for reduction ops
  always_comb begin
    alu_a = komut[5:3];
    alu_b = komut[2:0];
    alu_y = '0;
    unique case (komut[8:6])
      3'd0: alu_y = {1'b0, alu_a} + {1'b0, alu_b};
      3'd1: alu_y = {1'b0, alu_a} - {1'b0, alu_b};
      3'd2: alu_y = {1'b0, alu_a & alu_b};
      3'd3: alu_y = {1'b0, alu_a | alu_b};
      3'd4: alu_y = {3'b000, &alu_b};
      3'd5: alu_y = {3'b000, |alu_b};
      3'd6: alu_y = {3'b000, ^alu_b};
      3'd7: alu_y = {3'b000, ~^alu_b};
    endcase
  end

  // Under contention the priority bit picks; otherwise the lone requester wins
  always_comb begin
    talep   = istek0 | istek1;
    kazanan = (istek0 & istek1) ? oncelik : istek1;
  end

  // Next-state and grant decode
  always_comb begin
    durum_n   = durum;
    komut_n   = komut;
    sonuc_n   = sonuc;
    gecerli_n = sonuc_gecerli;
    kim_n     = sonuc_kim;
    oncelik_n = oncelik;
    sayac_n   = islem_sayaci;
    kabul0    = 1'b0;
    kabul1    = 1'b0;
    unique case (durum)
      BOSTA: begin
        if (talep && !rst) begin
          kabul0    = ~kazanan;
          kabul1    = kazanan;
          komut_n   = kazanan ? buyruk1 : buyruk0;
          kim_n     = kazanan;
          oncelik_n = ~kazanan;
          durum_n   = YURUT;
        end
      end
      YURUT: begin
        sonuc_n   = alu_y;
        gecerli_n = 1'b1;
        durum_n   = SUNUM;
      end
      SUNUM: begin
        if (sonuc_al) begin
          gecerli_n = 1'b0;
          sayac_n   = islem_sayaci + SAYAC_W'(1);
          durum_n   = BOSTA;
        end
      end
      default: durum_n = BOSTA;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      durum         <= BOSTA;
      komut         <= '0;
      sonuc         <= '0;
      sonuc_gecerli <= 1'b0;
      sonuc_kim     <= 1'b0;
      oncelik       <= 1'b0;
      islem_sayaci  <= '0;
    end else begin
      durum         <= durum_n;
      komut         <= komut_n;
      sonuc         <= sonuc_n;
      sonuc_gecerli <= gecerli_n;
      sonuc_kim     <= kim_n;
      oncelik       <= oncelik_n;
      islem_sayaci  <= sayac_n;
    end
  end

endmodule

// File: tb/tb_bib_hakem.sv
// Directed and randomized bench for bib_hakem against an arithmetic reference model.
module tb_bib_hakem;

  logic       clk = 1'b0;
  logic       rst;
  logic       istek0, istek1, sonuc_al;
  logic [8:0] buyruk0, buyruk1;
  logic       kabul0, kabul1, sonuc_gecerli, sonuc_kim;
  logic [3:0] sonuc;
  logic [7:0] islem_sayaci;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // reference model state
  int m_onc, m_cnt, m_son, m_kim;
  bit pend0, pend1;
  logic [8:0] pb0, pb1;
  int grant_cyc, prev_grant;

  bib_hakem dut (
    .clk(clk), .rst(rst),
    .istek0(istek0), .buyruk0(buyruk0), .kabul0(kabul0),
    .istek1(istek1), .buyruk1(buyruk1), .kabul1(kabul1),
    .sonuc(sonuc), .sonuc_gecerli(sonuc_gecerli), .sonuc_kim(sonuc_kim),
    .sonuc_al(sonuc_al), .islem_sayaci(islem_sayaci)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int ref_alu(input logic [8:0] ins);
    int op   = int'(ins[8:6]);
    int a    = int'(ins[5:3]);
    int b    = int'(ins[2:0]);
    int ones = $countones(ins[2:0]);
    case (op)
      0: return a + b;
      1: return (a - b + 16) % 16;
      2: return a & b;
      3: return a | b;
      4: return (b == 7) ? 1 : 0;
      5: return (b != 0) ? 1 : 0;
      6: return ones % 2;
      default: return (ones % 2 == 0) ? 1 : 0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_sonuc"}, 32'(sonuc), 32'(m_son));
    chk({tag, "_gecerli"}, 32'(sonuc_gecerli), 0);
    chk({tag, "_kim"}, 32'(sonuc_kim), 32'(m_kim));
    chk({tag, "_sayac"}, 32'(islem_sayaci), 32'(m_cnt));
  endtask

  task automatic model_reset;
    m_onc = 0; m_cnt = 0; m_son = 0; m_kim = 0;
    pend0 = 0; pend1 = 0;
  endtask

  task automatic do_reset;
    istek0 = 0; istek1 = 0; sonuc_al = 0;
    rst = 1;
    tick;
    rst = 0;
    model_reset();
    #1;
    chk_idle_outputs("rst");
  endtask

  // one full transaction from BOSTA: grant, execute, present, optional stall, consume
  task automatic run_op(input bit r0, input bit r1, input logic [8:0] b0,
                        input logic [8:0] b1, input int stall, input bit late0);
    int w, exp;
    if (pend0) begin r0 = 1; b0 = pb0; end
    if (pend1) begin r1 = 1; b1 = pb1; end
    istek0 = r0; buyruk0 = b0; istek1 = r1; buyruk1 = b1; sonuc_al = 0;
    #1;
    w = (r0 && r1) ? m_onc : (r0 ? 0 : 1);
    chk("grant_kabul0", 32'(kabul0), 32'(w == 0));
    chk("grant_kabul1", 32'(kabul1), 32'(w == 1));
    exp   = ref_alu(w == 1 ? b1 : b0);
    m_onc = 1 - w;
    pend0 = r0 && (w == 1); pb0 = b0;
    pend1 = r1 && (w == 0); pb1 = b1;
    tick;
    prev_grant = grant_cyc;
    grant_cyc  = cyc;
    if (w == 0) istek0 = 0; else istek1 = 0;
    if (late0 && w == 1) begin
      istek0 = 1; buyruk0 = 9'($urandom); pend0 = 1; pb0 = buyruk0;
    end
    #1;
    chk("yurut_kabul0", 32'(kabul0), 0);
    chk("yurut_kabul1", 32'(kabul1), 0);
    chk("yurut_gecerli", 32'(sonuc_gecerli), 0);
    tick;
    m_son = exp; m_kim = w;
    chk("sunum_gecerli", 32'(sonuc_gecerli), 1);
    chk("sunum_sonuc", 32'(sonuc), 32'(exp));
    chk("sunum_kim", 32'(sonuc_kim), 32'(w));
    for (int i = 0; i < stall; i++) begin
      tick;
      chk("stall_gecerli", 32'(sonuc_gecerli), 1);
      chk("stall_sonuc", 32'(sonuc), 32'(exp));
      chk("stall_kabul", 32'({kabul1, kabul0}), 0);
    end
    sonuc_al = 1;
    #1;
    chk("al_kabul", 32'({kabul1, kabul0}), 0);
    tick;
    sonuc_al = 0;
    m_cnt = (m_cnt + 1) % 256;
    chk_idle_outputs("consumed");
  endtask

  initial begin
    int r0, r1;
    istek0 = 0; istek1 = 0; buyruk0 = '0; buyruk1 = '0; sonuc_al = 0;
    grant_cyc = 0; prev_grant = 0;
    model_reset();

    // 1: reset with random inputs, then idle after release
    rst = 1;
    for (int i = 0; i < 5; i++) begin
      istek0 = 1'($urandom); istek1 = 1'($urandom); sonuc_al = 1'($urandom);
      buyruk0 = 9'($urandom); buyruk1 = 9'($urandom);
      tick;
      chk_idle_outputs("inrst");
      chk("inrst_kabul", 32'({kabul1, kabul0}), 0);
    end
    istek0 = 0; istek1 = 0; sonuc_al = 0;
    rst = 0;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk_idle_outputs("postrst");
      chk("postrst_kabul", 32'({kabul1, kabul0}), 0);
    end

    // 2: single add 5+3
    run_op(1, 0, 9'b000_101_011, 9'h0, 0, 0);
    chk("add_const", 32'(sonuc), 32'h8);
    chk("add_cnt", 32'(islem_sayaci), 1);

    // 3: contention from reset, requester 0 first
    do_reset();
    run_op(1, 1, 9'b001_011_101, 9'b111_000_011, 0, 0);
    chk("cont0_const", 32'(sonuc), 32'he);
    run_op(0, 0, 9'h0, 9'h0, 0, 0);
    chk("cont1_const", 32'(sonuc), 32'h1);
    chk("cont1_kim", 32'(sonuc_kim), 1);
    chk("cont_gap", 32'(grant_cyc - prev_grant), 3);

    // 4: backpressure with requester 0 waiting
    run_op(0, 1, 9'h0, 9'b000_111_111, 5, 1);
    chk("bp_const", 32'(sonuc), 32'he);
    run_op(0, 0, 9'h0, 9'h0, 0, 0);

    // 5: 256 back-to-back random ops cover the 255->0 wrap
    for (int i = 0; i < 256; i++) begin
      r0 = int'($urandom_range(0, 1));
      r1 = (r0 == 0) ? 1 : int'($urandom_range(0, 1));
      run_op(1'(r0), 1'(r1), 9'($urandom), 9'($urandom), 0, 0);
      if (m_cnt == 255) chk("wrap_255", 32'(islem_sayaci), 255);
      if (m_cnt == 0)   chk("wrap_0", 32'(islem_sayaci), 0);
    end

    // random stalls
    for (int i = 0; i < 30; i++) begin
      r0 = int'($urandom_range(0, 1));
      r1 = (r0 == 0) ? 1 : int'($urandom_range(0, 1));
      run_op(1'(r0), 1'(r1), 9'($urandom), 9'($urandom), int'($urandom_range(0, 3)), 0);
    end
    while (pend0 || pend1) run_op(0, 0, 9'h0, 9'h0, 0, 0);

    // 6: reset during YURUT, then during SUNUM
    for (int ph = 1; ph <= 2; ph++) begin
      istek0 = 1; buyruk0 = 9'b000_111_111; istek1 = 0;
      #1;
      chk("mid_grant", 32'(kabul0), 1);
      tick;
      if (ph == 2) tick;
      rst = 1;
      #1;
      model_reset();
      chk_idle_outputs("mid_inrst");
      chk("mid_kabul_forced", 32'({kabul1, kabul0}), 0);
      istek0 = 0;
      #1;
      rst = 0;
      for (int i = 0; i < 2; i++) begin
        tick;
        chk_idle_outputs("mid_after");
      end
      run_op(0, 1, 9'h0, 9'b011_100_010, 0, 0);
      chk("mid_next", 32'(sonuc), 32'h6);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bib_hakem.md
# bib_hakem

Two-requester round-robin arbiter and sequencer for the shared 3-bit-opcode ALU (9-bit `buyruk`, 4-bit `sonuc`). It accepts one instruction at a time from either requester through a valid/ready handshake and executes it on an ALU instance held inside the block. It registers the result and holds it until the consumer takes it, then counts the completed operation. It sits between the instruction sources and the result consumer, so the ALU itself never has to be shared by hand.

## Interface
- No parameters.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `istek0`  in  1  requester 0 has an instruction; must hold until `kabul0`.
- `buyruk0`  in  9  requester 0 instruction: [8:6] opcode, [5:3] A, [2:0] B; stable while `istek0`.
- `kabul0`  out  1  combinational grant; transfer occurs on an edge where `istek0 && kabul0`.
- `istek1`, `buyruk1`, `kabul1`: same as above, for requester 1.
- `sonuc`  out  4  registered ALU result.
- `sonuc_gecerli`  out  1  `sonuc`/`sonuc_kim` are valid.
- `sonuc_kim`  out  1  index of the requester that owns `sonuc`.
- `sonuc_al`  in  1  consumer ready; result is consumed on an edge where `sonuc_gecerli && sonuc_al`.
- `islem_sayaci`  out  8  count of consumed results; wraps 255→0.

## Operation
- ALU function, with A=[5:3], B=[2:0] and the 4-bit result zero-extended:
  - 000: A+B (carry kept in bit 3)
  - 001: A−B mod 16
  - 010: A&B
  - 011: A|B
  - 100: bit0 = &B
  - 101: bit0 = |B
  - 110: bit0 = ^B
  - 111: bit0 = ~^B
  - For 100–111, bits [3:1] are 0.
- FSM states: BOSTA (idle), YURUT (execute), SUNUM (present).
- BOSTA:
  - If neither `istek` is high, stay in BOSTA and drive both `kabul` low.
  - If exactly one `istek` is high, grant that requester.
  - If both are high, grant the requester selected by the priority bit `oncelik`.
  - Exactly one `kabul` is high, and only in BOSTA.
  - On the granting edge: latch the instruction into an internal register, latch the winner into `sonuc_kim`, set `oncelik` to the loser (the other index), and go to YURUT.
- YURUT:
  - Feed the latched instruction to the ALU.
  - On the next edge, register the ALU output into `sonuc`, set `sonuc_gecerli`, and go to SUNUM.
  - Both `kabul` are low.
- SUNUM:
  - Hold `sonuc`, `sonuc_kim` and `sonuc_gecerli=1` unchanged.
  - Both `kabul` are low; new requests wait.
  - On an edge with `sonuc_al=1`: clear `sonuc_gecerli`, increment `islem_sayaci`, go to BOSTA.
  - `sonuc` and `sonuc_kim` keep their last values after consumption.
- `buyruk` changes while `istek` is high and not yet granted are not checked; the value sampled on the grant edge is the one executed.

## Timing
- Reset values:
  - state = BOSTA
  - `sonuc` = 0, `sonuc_gecerli` = 0, `sonuc_kim` = 0
  - `islem_sayaci` = 0, `oncelik` = 0
  - `kabul0` and `kabul1` are forced to 0 while `rst` is high.
- Latency:
  - Grant edge = E.
  - `sonuc_gecerli` rises after edge E+1.
  - Earliest consume is edge E+2.
  - Earliest next grant is edge E+3, giving a peak throughput of one operation per 3 cycles.
- `kabul` depends combinationally on state, `istek*` and `oncelik`; there is no combinational path from `sonuc_al`.
- A requester that keeps `istek` asserted across operations gets alternating grants under contention. A lone requester is granted on every BOSTA cycle.
- Reset asserted mid-operation (YURUT or SUNUM):
  - The in-flight instruction is discarded and no result is presented.
  - The counter is not incremented; it clears to 0.
- Counter wrap: the 256th consume changes 255→0, with no flag.

## Test plan
1. Reset: assert `rst` with random inputs → all outputs 0 and both `kabul` 0 throughout; after release with no `istek`, outputs stay 0.
2. Single add: `istek0=1`, `buyruk0=9'b000_101_011`, `sonuc_al=1` → `kabul0` high 1 cycle; `sonuc=4'b1000`, `sonuc_kim=0`, `sonuc_gecerli` high exactly 1 cycle; `islem_sayaci=1`.
3. Contention from reset:
   - Stimulus: both `istek` held; `buyruk0=9'b001_011_101` (3−5), `buyruk1=9'b111_000_011` (XNOR-reduce of 011); `sonuc_al=1`.
   - Required: requester 0 served first with `sonuc=4'b1110`, `sonuc_kim=0`; then requester 1 with `sonuc=4'b0001`, `sonuc_kim=1`; grants 3 cycles apart.
4. Backpressure:
   - Stimulus: `buyruk1=9'b000_111_111`, `sonuc_al=0` for 5 cycles after valid, `istek0` held high.
   - Required: `sonuc=4'b1110` stable, `sonuc_gecerli=1`, both `kabul` 0 during the stall; `kabul0` rises the cycle after `sonuc_al` is consumed.
5. Counter wrap: 256 back-to-back consumed ops → `islem_sayaci` reads 255 then 0.
6. Reset mid-operation: pulse `rst` during YURUT → no `sonuc_gecerli`; state BOSTA; `islem_sayaci=0`; the next request is granted normally.
